// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte framing path: parser state encoding and error codes.
package uart_pkg;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_CMD     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_HOLD    = 3'd5
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Signal bundle between the frame parser (master) and its receiver, payload buffer and consumer (slave).
interface uart_frame_parser_if #(
  parameter int ADDR_W = 4
);
  logic              i_Rx_DV;
  logic [7:0]        i_Rx_Byte;
  logic              o_Pl_We;
  logic [ADDR_W-1:0] o_Pl_Addr;
  logic [7:0]        o_Pl_Data;
  logic              o_Frame_Valid;
  logic [7:0]        o_Cmd;
  logic [7:0]        o_Len;
  logic              i_Frame_Ack;
  logic              o_Err;
  logic [2:0]        o_Err_Code;
  logic [7:0]        o_Err_Count;

  modport master (
    input  i_Rx_DV, i_Rx_Byte, i_Frame_Ack,
    output o_Pl_We, o_Pl_Addr, o_Pl_Data, o_Frame_Valid, o_Cmd, o_Len,
           o_Err, o_Err_Code, o_Err_Count
  );

  modport slave (
    output i_Rx_DV, i_Rx_Byte, i_Frame_Ack,
    input  o_Pl_We, o_Pl_Addr, o_Pl_Data, o_Frame_Valid, o_Cmd, o_Len,
           o_Err, o_Err_Code, o_Err_Count
  );
endinterface

// File: rtl/uart_timeout_cnt.sv
// Idle-cycle counter: cleared by activity, held at zero while disabled, flags the terminal count.
module uart_timeout_cnt #(
  parameter int               CNT_W  = 20,
  parameter logic [CNT_W-1:0] TC_VAL = '1
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (!i_Enable || i_Clear) begin
      cnt <= '0;
    end else if (cnt != TC_VAL) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Activity in the same cycle beats the terminal count.
  assign o_Tc = i_Enable && !i_Clear && (cnt == TC_VAL);

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: SOF | LEN | CMD | payload | CHK, with payload buffer writes, valid/ack and error reporting.
//   S_HUNT    | waiting for SOF, other bytes dropped
//   S_LEN     | expecting length byte
//   S_CMD     | expecting command byte
//   S_PAYLOAD | writing payload bytes to the buffer
//   S_CHK     | expecting checksum byte
//   S_HOLD    | validated frame pending until ack
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE     = 8'hAA,
  parameter int          MAX_LEN      = 16,
  parameter int          ADDR_W       = 4,
  parameter logic [19:0] TIMEOUT_CLKS = 20'd20000
) (
  input logic                 i_Clock,
  input logic                 i_Rst_n,
  uart_frame_parser_if.master bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e            state_q, state_d;
  logic [7:0]        len_q, cmd_q, sum_q, pl_cnt_q;
  logic              pl_we_q;
  logic [ADDR_W-1:0] pl_addr_q;
  logic [7:0]        pl_data_q;
  logic [7:0]        out_cmd_q, out_len_q;
  logic              err_q;
  logic [2:0]        err_code_q;
  logic [7:0]        err_cnt_q;

  logic       dv, ack;
  logic [7:0] rx_byte;
  logic       len_bad, last_byte, chk_ok, to_en, to_tc;
  logic       pl_wr, frame_set, err_det;
  logic [2:0] err_code_d;

  assign dv        = bus.i_Rx_DV;
  assign ack       = bus.i_Frame_Ack;
  assign rx_byte   = bus.i_Rx_Byte;
  assign len_bad   = (rx_byte == 8'd0) || (rx_byte > MAX_LEN_B);
  assign last_byte = (pl_cnt_q == (len_q - 8'd1));
  assign chk_ok    = (rx_byte == sum_q);
  assign to_en     = (state_q == S_LEN) || (state_q == S_CMD) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CHK);

  uart_timeout_cnt #(
    .CNT_W  (20),
    .TC_VAL (TIMEOUT_CLKS - 20'd1)
  ) u_timeout (
    .i_Clock  (i_Clock),
    .i_Rst_n  (i_Rst_n),
    .i_Clear  (dv),
    .i_Enable (to_en),
    .o_Tc     (to_tc)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_HUNT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HUNT:    if (dv && rx_byte == SOF_BYTE) state_d = S_LEN;
      S_LEN:     if (dv) state_d = len_bad ? S_HUNT : S_CMD;
                 else if (to_tc) state_d = S_HUNT;
      S_CMD:     if (dv) state_d = S_PAYLOAD;
                 else if (to_tc) state_d = S_HUNT;
      S_PAYLOAD: if (dv) begin
                   if (last_byte) state_d = S_CHK;
                 end else if (to_tc) state_d = S_HUNT;
      S_CHK:     if (dv) state_d = chk_ok ? S_HOLD : S_HUNT;
                 else if (to_tc) state_d = S_HUNT;
      // Ack wins over a coincident byte, which is then judged as in S_HUNT.
      S_HOLD:    if (ack) state_d = (dv && rx_byte == SOF_BYTE) ? S_LEN : S_HUNT;
      default:   state_d = S_HUNT;
    endcase
  end

  always_comb begin
    pl_wr      = 1'b0;
    frame_set  = 1'b0;
    err_det    = 1'b0;
    err_code_d = ERR_NONE;
    case (state_q)
      S_LEN:     if (dv && len_bad) begin
                   err_det    = 1'b1;
                   err_code_d = ERR_LEN;
                 end
      S_PAYLOAD: pl_wr = dv;
      S_CHK:     if (dv) begin
                   if (chk_ok) begin
                     frame_set = 1'b1;
                   end else begin
                     err_det    = 1'b1;
                     err_code_d = ERR_CHK;
                   end
                 end
      S_HOLD:    if (dv && !ack) begin
                   err_det    = 1'b1;
                   err_code_d = ERR_OVERRUN;
                 end
      default:   ;
    endcase
    if (to_tc) begin
      err_det    = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      len_q      <= '0;
      cmd_q      <= '0;
      sum_q      <= '0;
      pl_cnt_q   <= '0;
      pl_we_q    <= 1'b0;
      pl_addr_q  <= '0;
      pl_data_q  <= '0;
      out_cmd_q  <= '0;
      out_len_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_cnt_q  <= '0;
    end else begin
      if (dv) begin
        case (state_q)
          S_LEN: begin
            len_q <= rx_byte;
            sum_q <= rx_byte;
          end
          S_CMD: begin
            cmd_q    <= rx_byte;
            sum_q    <= sum_q + rx_byte;
            pl_cnt_q <= '0;
          end
          S_PAYLOAD: begin
            sum_q    <= sum_q + rx_byte;
            pl_cnt_q <= pl_cnt_q + 8'd1;
          end
          default: ;
        endcase
      end
      pl_we_q <= pl_wr;
      if (pl_wr) begin
        pl_addr_q <= pl_cnt_q[ADDR_W-1:0];
        pl_data_q <= rx_byte;
      end
      if (frame_set) begin
        out_cmd_q <= cmd_q;
        out_len_q <= len_q;
      end
      err_q <= err_det;
      if (err_det) begin
        err_code_q <= err_code_d;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.o_Pl_We       = pl_we_q;
  assign bus.o_Pl_Addr     = pl_addr_q;
  assign bus.o_Pl_Data     = pl_data_q;
  assign bus.o_Frame_Valid = (state_q == S_HOLD);
  assign bus.o_Cmd         = out_cmd_q;
  assign bus.o_Len         = out_len_q;
  assign bus.o_Err         = err_q;
  assign bus.o_Err_Code    = err_code_q;
  assign bus.o_Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame-level byte-queue model checked every cycle, plus literal spot checks.
module tb_uart_frame_parser;

  localparam int          MAX_LEN = 16;
  localparam int          ADDR_W  = 4;
  localparam int          TMO     = 40;
  localparam logic [7:0]  SOF     = 8'hAA;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_frame_parser_if #(.ADDR_W(ADDR_W)) bus ();

  uart_frame_parser #(
    .SOF_BYTE     (SOF),
    .MAX_LEN      (MAX_LEN),
    .ADDR_W       (ADDR_W),
    .TIMEOUT_CLKS (20'(TMO))
  ) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: bytes since SOF are collected in a queue and judged by position.
  bit              in_frame = 0;
  bit              holding  = 0;
  logic [7:0]      frm[$];
  int              idle     = 0;
  logic            exp_we   = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [7:0]      exp_data = 0;
  logic            exp_valid = 0;
  logic [7:0]      exp_cmd  = 0;
  logic [7:0]      exp_len  = 0;
  logic            exp_err  = 0;
  logic [2:0]      exp_code = 0;
  logic [7:0]      exp_cnt  = 0;

  task automatic model_err(input logic [2:0] c);
    exp_err  = 1'b1;
    exp_code = c;
    if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame = 0; holding = 0; frm.delete(); idle = 0;
      exp_we = 0; exp_addr = '0; exp_data = 0; exp_valid = 0; exp_cmd = 0; exp_len = 0;
      exp_err = 0; exp_code = 0; exp_cnt = 0;
    end else begin
      logic dv;
      logic [7:0] b;
      int n, s;
      dv = bus.i_Rx_DV;
      b  = bus.i_Rx_Byte;
      exp_we  = 1'b0;
      exp_err = 1'b0;
      if (holding) begin
        if (bus.i_Frame_Ack) begin
          holding = 0; exp_valid = 0;
          if (dv && b == SOF) begin in_frame = 1; frm.delete(); idle = 0; end
        end else if (dv) begin
          model_err(3'd4);
        end
      end else if (in_frame) begin
        if (dv) begin
          idle = 0;
          frm.push_back(b);
          n = frm.size();
          if (n == 1) begin
            if (b == 8'd0 || int'(b) > MAX_LEN) begin model_err(3'd1); in_frame = 0; end
          end else if (n >= 3 && n <= int'(frm[0]) + 2) begin
            exp_we = 1'b1; exp_addr = ADDR_W'(n - 3); exp_data = b;
          end else if (n == int'(frm[0]) + 3) begin
            s = 0;
            for (int i = 0; i < n - 1; i++) s += int'(frm[i]);
            if (8'(s) == b) begin
              holding = 1; exp_valid = 1; exp_cmd = frm[1]; exp_len = frm[0];
            end else begin
              model_err(3'd2);
            end
            in_frame = 0;
          end
        end else begin
          idle++;
          if (idle == TMO) begin model_err(3'd3); in_frame = 0; end
        end
      end else if (dv && b == SOF) begin
        in_frame = 1; frm.delete(); idle = 0;
      end
    end
  end

  logic [ADDR_W-1:0] wlog_a[$];
  logic [7:0]        wlog_d[$];

  always @(negedge clk) begin
    chk("pl_we", 32'(bus.o_Pl_We), 32'(exp_we));
    if (exp_we) begin
      chk("pl_addr", 32'(bus.o_Pl_Addr), 32'(exp_addr));
      chk("pl_data", 32'(bus.o_Pl_Data), 32'(exp_data));
    end
    chk("frame_valid", 32'(bus.o_Frame_Valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("cmd", 32'(bus.o_Cmd), 32'(exp_cmd));
      chk("len", 32'(bus.o_Len), 32'(exp_len));
    end
    chk("err", 32'(bus.o_Err), 32'(exp_err));
    chk("err_code", 32'(bus.o_Err_Code), 32'(exp_code));
    chk("err_count", 32'(bus.o_Err_Count), 32'(exp_cnt));
    if (bus.o_Pl_We) begin
      wlog_a.push_back(bus.o_Pl_Addr);
      wlog_d.push_back(bus.o_Pl_Data);
    end
  end

  task automatic idle_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = b;
    @(negedge clk);
    bus.i_Rx_DV = 1'b0;
  endtask

  task automatic send_list(input bq_t q);
    foreach (q[i]) begin
      send(q[i]);
      idle_cyc(1);
    end
  endtask

  task automatic ack();
    @(negedge clk);
    bus.i_Frame_Ack = 1'b1;
    @(negedge clk);
    bus.i_Frame_Ack = 1'b0;
  endtask

  bq_t q;

  initial begin
    bus.i_Rx_DV = 1'b0; bus.i_Rx_Byte = 8'h00; bus.i_Frame_Ack = 1'b0;
    idle_cyc(2);
    @(negedge clk); #2 rst_n = 1'b1;
    idle_cyc(1);
    chk("rst_valid", 32'(bus.o_Frame_Valid), 32'd0);
    chk("rst_code", 32'(bus.o_Err_Code), 32'd0);
    chk("rst_count", 32'(bus.o_Err_Count), 32'd0);

    // Good frame
    wlog_a.delete(); wlog_d.delete();
    q = '{8'hAA, 8'h02, 8'h10, 8'h01, 8'h02};
    send_list(q);
    send(8'h15);
    chk("good_valid", 32'(bus.o_Frame_Valid), 32'd1);
    chk("good_cmd", 32'(bus.o_Cmd), 32'h10);
    chk("good_len", 32'(bus.o_Len), 32'h02);
    chk("good_nwr", 32'(wlog_a.size()), 32'd2);
    if (wlog_a.size() == 2) begin
      chk("good_wr0", {wlog_a[0], wlog_d[0]}, {4'd0, 8'h01});
      chk("good_wr1", {wlog_a[1], wlog_d[1]}, {4'd1, 8'h02});
    end
    ack();
    chk("good_ack_valid", 32'(bus.o_Frame_Valid), 32'd0);
    chk("good_no_err", 32'(bus.o_Err_Count), 32'd0);

    // Bad checksum, then a good frame
    q = '{8'hAA, 8'h02, 8'h10, 8'h01, 8'h02};
    send_list(q);
    send(8'h16);
    chk("badchk_err", 32'(bus.o_Err), 32'd1);
    chk("badchk_code", 32'(bus.o_Err_Code), 32'd2);
    chk("badchk_cnt", 32'(bus.o_Err_Count), 32'd1);
    chk("badchk_valid", 32'(bus.o_Frame_Valid), 32'd0);
    idle_cyc(2);
    q = '{8'hAA, 8'h01, 8'h33, 8'h44};
    send_list(q);
    send(8'h78);
    chk("after_bad_valid", 32'(bus.o_Frame_Valid), 32'd1);
    chk("after_bad_cmd", 32'(bus.o_Cmd), 32'h33);
    ack();

    // Length violations; trailing 0x10 ignored in hunt
    send(8'hAA); send(8'h00);
    chk("len0_code", 32'(bus.o_Err_Code), 32'd1);
    idle_cyc(1);
    send(8'hAA); send(8'h11);
    chk("len17_code", 32'(bus.o_Err_Code), 32'd1);
    chk("len17_cnt", 32'(bus.o_Err_Count), 32'd3);
    send(8'h10);
    idle_cyc(2);
    chk("len_trail_cnt", 32'(bus.o_Err_Count), 32'd3);

    // Timeout, then recovery
    send(8'hAA); send(8'h01);
    idle_cyc(TMO + 3);
    chk("tmo_code", 32'(bus.o_Err_Code), 32'd3);
    chk("tmo_cnt", 32'(bus.o_Err_Count), 32'd4);
    q = '{8'hAA, 8'h01, 8'h05, 8'h07};
    send_list(q);
    send(8'h0D);
    chk("tmo_rec_valid", 32'(bus.o_Frame_Valid), 32'd1);
    chk("tmo_rec_cmd", 32'(bus.o_Cmd), 32'h05);
    ack();

    // Overrun in hold, then ack coincident with SOF
    q = '{8'hAA, 8'h02, 8'h10, 8'h01, 8'h02};
    send_list(q);
    send(8'h15);
    idle_cyc(2);
    send(8'h55);
    chk("ovr_err", 32'(bus.o_Err), 32'd1);
    chk("ovr_code", 32'(bus.o_Err_Code), 32'd4);
    chk("ovr_cnt", 32'(bus.o_Err_Count), 32'd5);
    chk("ovr_valid", 32'(bus.o_Frame_Valid), 32'd1);
    chk("ovr_cmd", 32'(bus.o_Cmd), 32'h10);
    @(negedge clk);
    bus.i_Frame_Ack = 1'b1; bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = 8'hAA;
    @(negedge clk);
    bus.i_Frame_Ack = 1'b0; bus.i_Rx_DV = 1'b0;
    chk("coll_valid", 32'(bus.o_Frame_Valid), 32'd0);
    q = '{8'h01, 8'h09, 8'h09};
    send_list(q);
    send(8'h13);
    chk("coll_next_valid", 32'(bus.o_Frame_Valid), 32'd1);
    chk("coll_next_cmd", 32'(bus.o_Cmd), 32'h09);
    chk("coll_next_len", 32'(bus.o_Len), 32'h01);
    ack();

    // Reset mid-payload
    q = '{8'hAA, 8'h03, 8'h20, 8'h01};
    send_list(q);
    @(negedge clk); #2 rst_n = 1'b0;
    idle_cyc(2);
    chk("midrst_we", 32'(bus.o_Pl_We), 32'd0);
    chk("midrst_addr", 32'(bus.o_Pl_Addr), 32'd0);
    chk("midrst_err", 32'(bus.o_Err), 32'd0);
    chk("midrst_code", 32'(bus.o_Err_Code), 32'd0);
    chk("midrst_cnt", 32'(bus.o_Err_Count), 32'd0);
    chk("midrst_cmd", 32'(bus.o_Cmd), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    idle_cyc(1);
    q = '{8'hAA, 8'h02, 8'h10, 8'h01, 8'h02};
    send_list(q);
    send(8'h15);
    chk("post_rst_valid", 32'(bus.o_Frame_Valid), 32'd1);
    chk("post_rst_cnt", 32'(bus.o_Err_Count), 32'd0);
    ack();

    // Error counter saturation
    repeat (260) begin
      send(8'hAA);
      send(8'h00);
    end
    idle_cyc(2);
    chk("sat_cnt", 32'(bus.o_Err_Count), 32'd255);
    chk("sat_code", 32'(bus.o_Err_Code), 32'd1);

    idle_cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
